// File: rtl/bcd_display_formatter_if.sv
// Request/result bundle between an upstream binary source and the
// BCD display formatter.
interface bcd_display_formatter_if #(
    parameter int DIGITS    = 8,
    parameter int BIN_WIDTH = 32
);
    logic [BIN_WIDTH-1:0]  bin_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  valid_out;
    logic                  overflow_out;

    modport master (
        output bin_in,
        output valid_in,
        input  ready_out,
        input  bcd_out,
        input  valid_out,
        input  overflow_out
    );

    modport slave (
        input  bin_in,
        input  valid_in,
        output ready_out,
        output bcd_out,
        output valid_out,
        output overflow_out
    );
endinterface

// File: rtl/bcd_display_formatter.sv
// Iterative double-dabble binary-to-BCD converter, one shift-add-3 step
// per clock, saturating to all nines when the value has too many digits.
module bcd_display_formatter #(
    parameter int DIGITS    = 8,
    parameter int BIN_WIDTH = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    bcd_display_formatter_if.slave  io
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH) + 1;
    localparam int XW = 128;

    function automatic logic [XW-1:0] pow10(input int n);
        logic [XW-1:0] r;
        r = XW'(1);
        for (int i = 0; i < n; i++) begin
            r = r * XW'(10);
        end
        return r;
    endfunction

    localparam logic [XW-1:0]  LIMIT   = pow10(DIGITS);
    localparam logic [BW-1:0]  NINES   = {DIGITS{4'h9}};
    localparam logic [CW-1:0]  LAST_IT = CW'(BIN_WIDTH - 1);

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t                state_q;
    logic [BW-1:0]         acc_q;
    logic [BIN_WIDTH-1:0]  sh_q;
    logic [CW-1:0]         cnt_q;
    logic                  sat_q;
    logic                  ready_q;
    logic                  valid_q;
    logic                  ovf_q;
    logic [BW-1:0]         bcd_q;

    logic [BW-1:0]         adj;
    logic [BW-1:0]         acc_d;
    logic [BIN_WIDTH-1:0]  sh_d;
    logic [XW-1:0]         in_ext;
    logic                  sat_d;

    // Zero-extended so the range check never truncates the limit.
    assign in_ext = {{(XW-BIN_WIDTH){1'b0}}, io.bin_in};
    assign sat_d  = (in_ext >= LIMIT);

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        {acc_d, sh_d} = {adj, sh_q} << 1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (io.valid_in) begin
                        acc_q   <= '0;
                        sh_q    <= io.bin_in;
                        cnt_q   <= '0;
                        sat_q   <= sat_d;
                        ready_q <= 1'b0;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Saturated inputs still run every step: fixed latency.
                    if (cnt_q == LAST_IT) begin
                        bcd_q   <= sat_q ? NINES : acc_d;
                        ovf_q   <= sat_q;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.ready_out    = ready_q;
    assign io.valid_out    = valid_q;
    assign io.overflow_out = ovf_q;
    assign io.bcd_out      = bcd_q;
endmodule

// File: tb/tb_bcd_display_formatter.sv
// Scoreboard bench: drivers push decimal-model results, a negedge
// monitor pops and checks each valid_out pulse.
module tb_bcd_display_formatter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_display_formatter_if #(.DIGITS(8), .BIN_WIDTH(32)) bus ();

    bcd_display_formatter #(.DIGITS(8), .BIN_WIDTH(32)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .io     (bus.slave)
    );

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int unsigned t0;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic        prev_v = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint unsigned act,
                       input longint unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        longint unsigned x;
        x = v;
        e.ovf = (x >= 64'd100_000_000);
        if (e.ovf) x = 64'd99_999_999;
        e.bcd = '0;
        for (int k = 0; k < 8; k++) begin
            e.bcd[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        e.t0 = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (bus.valid_out) begin
            chk("pulse_width", prev_v, 0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid bcd_out=%h want=no_output",
                         bus.bcd_out);
            end else begin
                e = q.pop_front();
                chk("bcd_out", bus.bcd_out, e.bcd);
                chk("overflow", bus.overflow_out, e.ovf);
                chk("latency", cyc - e.t0, 32);
                ok = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    if (bus.bcd_out[4*k +: 4] > 4'd9) ok = 1'b0;
                end
                chk("nibble_le_9", ok, 1);
            end
        end
        prev_v = bus.valid_out;
    end

    // Called at posedge+#1; returns at the accepting edge +#1.
    task automatic go(input logic [31:0] v, output int unsigned t0);
        int n;
        exp_t e;
        n = 0;
        t0 = 0;
        while (!bus.ready_out) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                chk("ready_timeout", 0, 1);
                return;
            end
        end
        bus.bin_in   = v;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        e = model(v);
        e.t0 = cyc;
        t0 = cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, t1;
        logic [31:0] v;
        bus.bin_in   = '0;
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", bus.ready_out, 1);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_bcd", bus.bcd_out, 0);
        chk("rst_ovf", bus.overflow_out, 0);
        @(posedge clk); #1;

        go(32'd12_345_678, t0);
        for (int i = 0; i < 32; i++) begin
            chk("busy_ready_low", bus.ready_out, 0);
            @(posedge clk); #1;
        end
        chk("done_ready", bus.ready_out, 1);
        chk("done_valid", bus.valid_out, 1);
        drain();

        go(32'd0, t0);
        go(32'd99_999_999, t0);
        go(32'd100_000_000, t0);
        go(32'hFFFF_FFFF, t0);
        drain();

        go(32'd42, t0);
        repeat (3) @(posedge clk);
        #1;
        bus.bin_in   = 32'd5;
        bus.valid_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        drain();

        go(32'd123, t0);
        go(32'd7, t1);
        chk("b2b_gap", t1 - t0, 33);
        drain();

        go(32'd555, t0);
        repeat (9) @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.bin_in   = 32'd3;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        q.delete();
        bus.valid_in = 1'b0;
        chk("midrst_bcd", bus.bcd_out, 0);
        chk("midrst_ready", bus.ready_out, 1);
        chk("midrst_valid", bus.valid_out, 0);
        chk("midrst_ovf", bus.overflow_out, 0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        go(32'd909, t0);
        drain();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) v = $urandom;
            else v = $urandom_range(0, 99_999_999);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            go(v, t0);
        end
        drain();
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
